// File: rtl/shr_arbiter.sv
// shr_arbiter: four requesters share one logical-shift-right (zero fill) unit.
// A round-robin arbiter accepts one operation per cycle into a 2-stage pipe.
// Stage 1 captures the winner's operands. Stage 2 registers the result, which
// leaves on a single valid/ready bus tagged with the requester id.
//
// Ports:
//   Clk          clock, rising edge
//   Rst          asynchronous reset, active low
//   req[i]       request from requester i; held with stable operands until gnt[i]
//   a_in, sh_in  packed operands / shift amounts, lane i at [i*DATAWIDTH +: DATAWIDTH]
//   gnt          one-hot single-cycle grant; operands were captured on the raising edge
//   d, d_id      result and owning requester id
//   d_valid      d/d_id valid; held stable while d_ready is low
//   d_ready      consumer accepts on d_valid && d_ready
module shr_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] a_in,
  input  logic [NREQ*DATAWIDTH-1:0] sh_in,
  output logic [NREQ-1:0]           gnt,
  output logic [DATAWIDTH-1:0]      d,
  output logic [1:0]                d_id,
  output logic                      d_valid,
  input  logic                      d_ready
);

  localparam int IDW = 2;

  // Lane views of the flat operand buses (identical bit layout).
  logic [NREQ-1:0][DATAWIDTH-1:0] a_vec, sh_vec;
  assign a_vec  = a_in;
  assign sh_vec = sh_in;

  logic [IDW-1:0]       last;
  logic                 s1_v;
  logic [DATAWIDTH-1:0] s1_a, s1_sh;
  logic [IDW-1:0]       s1_id;

  logic                 stall;
  logic [NREQ-1:0]      elig;
  logic [IDW-1:0]       win, idx;
  logic                 found;

  assign stall = d_valid && !d_ready;
  // A requester still looking at its grant pulse may not have dropped req
  // yet; masking it stops a double grant for the same operation.
  assign elig  = req & ~gnt;

  // Round-robin search starting just after the last winner; the 2-bit add
  // wraps, so k == NREQ revisits the last winner at lowest priority.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + IDW'(k);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      gnt     <= '0;
      last    <= IDW'(NREQ - 1);
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_sh   <= '0;
      s1_id   <= '0;
      d       <= '0;
      d_id    <= '0;
      d_valid <= 1'b0;
    end else if (stall) begin
      // Whole pipe and pointer freeze; pending requests wait for the release.
      gnt <= '0;
    end else begin
      if (found) begin
        gnt   <= NREQ'(1) << win;
        last  <= win;
        s1_a  <= a_vec[win];
        s1_sh <= sh_vec[win];
        s1_id <= win;
        s1_v  <= 1'b1;
      end else begin
        gnt  <= '0;
        s1_v <= 1'b0;
      end
      d_valid <= s1_v;
      if (s1_v) begin
        // Shift amounts >= DATAWIDTH shift everything out: result is zero.
        d    <= s1_a >> s1_sh;
        d_id <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_shr_arbiter.sv
module tb_shr_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  req;
  logic [31:0] a_in, sh_in;
  logic [3:0]  gnt;
  logic [7:0]  d;
  logic [1:0]  d_id;
  logic        d_valid;
  logic        d_ready;

  int n_cmp = 0;
  int n_err = 0;

  shr_arbiter #(.DATAWIDTH(8), .NREQ(4)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .a_in(a_in), .sh_in(sh_in),
    .gnt(gnt), .d(d), .d_id(d_id), .d_valid(d_valid), .d_ready(d_ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] sh;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge and land 1 time unit after it for sampling/driving.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] sh);
    a_in[id*8 +: 8]  = a;
    sh_in[id*8 +: 8] = sh;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_d_id", 32'(d_id), 32'h0);
    chk("rst_d_valid", 32'(d_valid), 32'h0);
    tick();
    tick();
    Rst = 1'b1;
    tick();
  endtask

  initial begin
    vt[0] = '{0, 8'hF0, 8'd4,   8'h0F};
    vt[1] = '{1, 8'hFF, 8'd0,   8'hFF};
    vt[2] = '{2, 8'hFF, 8'd7,   8'h01};
    vt[3] = '{3, 8'hFF, 8'd8,   8'h00};
    vt[4] = '{0, 8'hFF, 8'hFF,  8'h00};
    vt[5] = '{1, 8'hA5, 8'd1,   8'h52};
    vt[6] = '{2, 8'h81, 8'd3,   8'h10};
    vt[7] = '{3, 8'h80, 8'd7,   8'h01};

    Rst = 1'b1; req = '0; a_in = '0; sh_in = '0; d_ready = 1'b1;
    #2;
    do_reset();

    // Single operations: grant pulse, result one edge later, then idle.
    for (int i = 0; i < 8; i++) begin
      set_op(vt[i].id, vt[i].a, vt[i].sh);
      req = 4'(1 << vt[i].id);
      tick();
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(1 << vt[i].id));
      chk($sformatf("v%0d_dv_early", i), 32'(d_valid), 32'h0);
      req = '0;
      tick();
      chk($sformatf("v%0d_gnt_pulse", i), 32'(gnt), 32'h0);
      chk($sformatf("v%0d_dv", i), 32'(d_valid), 32'h1);
      chk($sformatf("v%0d_d", i), 32'(d), 32'(vt[i].exp_d));
      chk($sformatf("v%0d_d_id", i), 32'(d_id), 32'(vt[i].id));
      tick();
      chk($sformatf("v%0d_dv_drop", i), 32'(d_valid), 32'h0);
    end

    // All four requesting continuously: round-robin, one result per cycle.
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'h80, 8'(i));
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1 << (k % 4)));
      if (k >= 1) begin
        chk($sformatf("rr%0d_dv", k), 32'(d_valid), 32'h1);
        chk($sformatf("rr%0d_d", k), 32'(d), 32'(8'h80 >> ((k - 1) % 4)));
        chk($sformatf("rr%0d_id", k), 32'(d_id), 32'((k - 1) % 4));
      end
    end
    req = '0;
    tick(); tick(); tick();
    chk("rr_drain_dv", 32'(d_valid), 32'h0);

    // Stall: two ops in flight, d_ready low 3 cycles, a new req0 arrives meanwhile.
    do_reset();
    set_op(0, 8'hF0, 8'd4);
    set_op(1, 8'hC3, 8'd1);
    req = 4'b0011;
    tick();
    chk("st_gnt0", 32'(gnt), 32'b0001);
    req = 4'b0010;
    tick();
    chk("st_gnt1", 32'(gnt), 32'b0010);
    chk("st_d0", 32'(d), 32'h0F);
    d_ready = 1'b0;
    req = 4'b0001;
    set_op(0, 8'hAA, 8'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("st_hold%0d_gnt", k), 32'(gnt), 32'h0);
      chk($sformatf("st_hold%0d_dv", k), 32'(d_valid), 32'h1);
      chk($sformatf("st_hold%0d_d", k), 32'(d), 32'h0F);
      chk($sformatf("st_hold%0d_id", k), 32'(d_id), 32'h0);
    end
    d_ready = 1'b1;
    tick();
    chk("st_rel_gnt", 32'(gnt), 32'b0001);
    chk("st_rel_dv", 32'(d_valid), 32'h1);
    chk("st_rel_d", 32'(d), 32'h61);
    chk("st_rel_id", 32'(d_id), 32'h1);
    req = '0;
    tick();
    chk("st_new_gnt", 32'(gnt), 32'h0);
    chk("st_new_d", 32'(d), 32'h0A);
    chk("st_new_id", 32'(d_id), 32'h0);
    chk("st_new_dv", 32'(d_valid), 32'h1);
    tick();
    chk("st_end_dv", 32'(d_valid), 32'h0);

    // Reset mid-stream discards in-flight ops.
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'h80, 8'(i));
    req = 4'hF;
    tick(); tick(); tick();
    chk("mr_busy_dv", 32'(d_valid), 32'h1);
    req = '0;
    do_reset();
    chk("mr_post_dv", 32'(d_valid), 32'h0);
    set_op(2, 8'hF0, 8'd0);
    req = 4'b0100;
    tick();
    chk("mr_gnt", 32'(gnt), 32'b0100);
    chk("mr_no_stale", 32'(d_valid), 32'h0);
    req = '0;
    tick();
    chk("mr_dv", 32'(d_valid), 32'h1);
    chk("mr_d", 32'(d), 32'hF0);
    chk("mr_id", 32'(d_id), 32'h2);
    tick();
    chk("mr_end_dv", 32'(d_valid), 32'h0);

    // req0 held one cycle late: exactly one grant and one result.
    do_reset();
    set_op(0, 8'hF0, 8'd4);
    req = 4'b0001;
    tick();
    chk("late_gnt", 32'(gnt), 32'b0001);
    tick();
    chk("late_no_regnt", 32'(gnt), 32'h0);
    chk("late_dv", 32'(d_valid), 32'h1);
    req = '0;
    tick();
    chk("late_gnt_idle", 32'(gnt), 32'h0);
    chk("late_dv_once", 32'(d_valid), 32'h0);
    tick();
    chk("late_dv_none", 32'(d_valid), 32'h0);

    // req0 held two cycles past its grant: second grant on the third edge.
    req = 4'b0001;
    tick();
    chk("hold2_gnt_a", 32'(gnt), 32'b0001);
    tick();
    chk("hold2_gap", 32'(gnt), 32'h0);
    tick();
    chk("hold2_gnt_b", 32'(gnt), 32'b0001);
    chk("hold2_dv_gap", 32'(d_valid), 32'h0);
    req = '0;
    tick();
    chk("hold2_dv_b", 32'(d_valid), 32'h1);
    chk("hold2_d_b", 32'(d), 32'h0F);
    tick();
    chk("hold2_end", 32'(d_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
